// File: rtl/cpsr_flag_unit.sv
// CPSR NZCV flag holder, ARM condition evaluator and flag-hazard interlock between issue and ALU.
// Optional macro FLAG_BYPASS_EN forwards a same-cycle final writeback into condition evaluation.
module cpsr_flag_unit #(
    parameter  int MAX_INFLIGHT = 3,
    localparam int PW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [3:0]    issue_cond,
    input  logic          issue_sets_flags,
    input  logic          flush,
    input  logic [3:0]    nzcv,
    input  logic          nzcv_writeback,
    output logic          exec_valid,
    output logic          exec_pass,
    output logic [3:0]    flags,
    output logic [PW-1:0] pending,
    output logic          wb_err
);

    localparam logic [PW-1:0] PEND_ONE = PW'(1'b1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_INFLIGHT);
    localparam logic [3:0]    COND_AL  = 4'd14;

    logic          bypass_s;
    logic [3:0]    eval_flags_s;
    logic          hazard_s;
    logic          full_s;
    logic          accept_s;
    logic          pass_s;
    logic          inc_s;
    logic          dec_s;
    logic [PW-1:0] pending_nxt_s;

    function automatic logic cond_pass_f(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, res;
        {n, z, c, v} = f;
        case (cond)
            4'd0:    res = z;
            4'd1:    res = !z;
            4'd2:    res = c;
            4'd3:    res = !c;
            4'd4:    res = n;
            4'd5:    res = !n;
            4'd6:    res = v;
            4'd7:    res = !v;
            4'd8:    res = c && !z;
            4'd9:    res = !c || z;
            4'd10:   res = (n == v);
            4'd11:   res = (n != v);
            4'd12:   res = !z && (n == v);
            4'd13:   res = z || (n != v);
            4'd14:   res = 1'b1;
            4'd15:   res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Issue interlock, condition evaluation and next pending count
    always_comb begin
        bypass_s = 1'b0;
`ifdef FLAG_BYPASS_EN
        // The last outstanding writeback is landing now; use its value directly.
        bypass_s = nzcv_writeback && (pending == PEND_ONE);
`endif
        eval_flags_s = bypass_s ? nzcv : flags;
        hazard_s     = (issue_cond != COND_AL) && (pending != '0) && !bypass_s;
        full_s       = issue_sets_flags && (pending == PEND_MAX);
        issue_ready  = !flush && !hazard_s && !full_s;
        accept_s     = issue_valid && issue_ready;
        pass_s       = cond_pass_f(issue_cond, eval_flags_s);
        inc_s        = accept_s && pass_s && issue_sets_flags;
        dec_s        = nzcv_writeback && (pending != '0);
        if (flush) begin
            pending_nxt_s = '0;
        end else if (inc_s && !dec_s) begin
            pending_nxt_s = pending + PEND_ONE;
        end else if (dec_s && !inc_s) begin
            pending_nxt_s = pending - PEND_ONE;
        end else begin
            pending_nxt_s = pending;
        end
    end

    // Architectural flags, pending counter, exec result and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags      <= 4'b0000;
            pending    <= '0;
            exec_valid <= 1'b0;
            exec_pass  <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            if (nzcv_writeback) begin
                flags <= nzcv;
            end
            if (nzcv_writeback && (pending == '0)) begin
                wb_err <= 1'b1;
            end
            pending    <= pending_nxt_s;
            exec_valid <= accept_s;
            exec_pass  <= accept_s && pass_s;
        end
    end

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// Self-checking bench for cpsr_flag_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_cpsr_flag_unit;

    localparam int MAXI = 3;
    localparam int PW   = $clog2(MAXI + 1);

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic          issue_ready;
    logic [3:0]    issue_cond;
    logic          issue_sets_flags;
    logic          flush;
    logic [3:0]    nzcv;
    logic          nzcv_writeback;
    logic          exec_valid;
    logic          exec_pass;
    logic [3:0]    flags;
    logic [PW-1:0] pending;
    logic          wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [3:0] m_flags;
    int         m_pending;
    bit         m_ev, m_ep, m_err;

    cpsr_flag_unit #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_cond(issue_cond), .issue_sets_flags(issue_sets_flags),
        .flush(flush), .nzcv(nzcv), .nzcv_writeback(nzcv_writeback),
        .exec_valid(exec_valid), .exec_pass(exec_pass),
        .flags(flags), .pending(pending), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ARM conditions come in pairs: odd codes are the negation of the even one below.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, b;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    function automatic bit m_bypass();
        return BYPASS && nzcv_writeback && (m_pending == 1);
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (issue_cond != 4'd14 && m_pending != 0 && !m_bypass()) return 1'b0;
        if (issue_sets_flags && m_pending == MAXI) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit acc, pass;
        logic [3:0] ef;
        int np;
        acc  = issue_valid && m_ready();
        ef   = m_bypass() ? nzcv : m_flags;
        pass = cond_holds(issue_cond, ef);
        np   = m_pending;
        if (acc && pass && issue_sets_flags) np = np + 1;
        if (nzcv_writeback && m_pending > 0) np = np - 1;
        if (nzcv_writeback && m_pending == 0) m_err = 1'b1;
        if (flush) np = 0;
        m_pending = np;
        m_ev = acc;
        m_ep = acc && pass;
        if (nzcv_writeback) m_flags = nzcv;
    endtask

    task automatic model_reset();
        m_flags = 4'b0000; m_pending = 0; m_ev = 0; m_ep = 0; m_err = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic sf,
                         input logic fl, input logic [3:0] nz, input logic wb);
        issue_valid = v; issue_cond = c; issue_sets_flags = sf;
        flush = fl; nzcv = nz; nzcv_writeback = wb;
        #1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        drive(1'b0, 4'd0, 1'b0, 1'b0, f, 1'b1); step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        n_checks++; if (pending !== '0 || exec_valid !== 1'b0 || exec_pass !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got pend=%0d ev=%b ep=%b err=%b expected all 0", pending, exec_valid, exec_pass, wb_err); end
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL pre_async_pending: got %0d expected 1", pending); end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (pending !== '0 || exec_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got pend=%0d ev=%b expected 0 0", pending, exec_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'b1100, 1'b1); step();
        n_checks++; if (wb_err !== 1'b1 || flags !== 4'b1100) begin
            n_fail++; $display("FAIL late_wb_after_reset: got err=%b flags=%b expected 1 1100", wb_err, flags); end
    endtask

    task automatic test_cond_basic();
        do_reset();
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", issue_ready); end
        step();
        n_checks++; if (exec_valid !== 1'b1 || exec_pass !== 1'b0) begin
            n_fail++; $display("FAIL basic_eq: got ev=%b ep=%b expected 1 0", exec_valid, exec_pass); end
        drive(1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_valid !== 1'b1 || exec_pass !== 1'b1 || flags !== 4'b0000) begin
            n_fail++; $display("FAIL basic_al: got ev=%b ep=%b flags=%b expected 1 1 0000", exec_valid, exec_pass, flags); end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_valid !== 1'b0 || exec_pass !== 1'b0) begin
            n_fail++; $display("FAIL idle_exec: got ev=%b ep=%b expected 0 0", exec_valid, exec_pass); end
    endtask

    task automatic test_hazard();
        do_reset();
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (pending !== 2'd1) begin n_fail++; $display("FAIL hazard_pend1: got %0d expected 1", pending); end
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_stall: got %b expected 0", issue_ready); end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'b0100, 1'b1); step();
        n_checks++; if (flags !== 4'b0100 || pending !== 2'd0) begin
            n_fail++; $display("FAIL hazard_wb: got flags=%b pend=%0d expected 0100 0", flags, pending); end
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_release: got %b expected 1", issue_ready); end
        step();
        n_checks++; if (exec_valid !== 1'b1 || exec_pass !== 1'b1 || pending !== 2'd0) begin
            n_fail++; $display("FAIL hazard_eq_pass: got ev=%b ep=%b pend=%0d expected 1 1 0", exec_valid, exec_pass, pending); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        end
        n_checks++; if (pending !== 2'd3) begin n_fail++; $display("FAIL full_pend3: got %0d expected 3", pending); end
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'b0011, 1'b1);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %b expected 0", issue_ready); end
        step();
        n_checks++; if (pending !== 2'd2 || exec_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got pend=%0d ev=%b expected 2 0", pending, exec_valid); end
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'b0011, 1'b1); step();
        n_checks++; if (pending !== 2'd2 || exec_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_inc_dec: got pend=%0d ev=%b expected 2 1", pending, exec_valid); end
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (pending !== 2'd3) begin n_fail++; $display("FAIL full_refill: got %0d expected 3", pending); end
        drive(1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_al_nonsetter: got %b expected 1", issue_ready); end
    endtask

    task automatic test_signed_conds();
        do_reset();
        set_flags(4'b1000);
        drive(1'b1, 4'd10, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_pass !== 1'b0) begin n_fail++; $display("FAIL ge_1000: got %b expected 0", exec_pass); end
        drive(1'b1, 4'd11, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_pass !== 1'b1) begin n_fail++; $display("FAIL lt_1000: got %b expected 1", exec_pass); end
        set_flags(4'b1001);
        drive(1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_pass !== 1'b1) begin n_fail++; $display("FAIL gt_1001: got %b expected 1", exec_pass); end
        drive(1'b1, 4'd13, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_pass !== 1'b0) begin n_fail++; $display("FAIL le_1001: got %b expected 0", exec_pass); end
        // failed condition on a flag-setter produces no pending writeback
        drive(1'b1, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (pending !== 2'd0 || exec_valid !== 1'b1) begin
            n_fail++; $display("FAIL nv_setter: got pend=%0d ev=%b expected 0 1", pending, exec_valid); end
    endtask

    task automatic test_wb_err();
        do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'b0010, 1'b1); step();
        n_checks++; if (wb_err !== 1'b1 || flags !== 4'b0010 || pending !== 2'd0) begin
            n_fail++; $display("FAIL wb_err_set: got err=%b flags=%b pend=%0d expected 1 0010 0", wb_err, flags, pending); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 1'b0); step();
        end
        n_checks++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wb_err_sticky: got %b expected 1", wb_err); end
        do_reset();
        n_checks++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL wb_err_clear: got %b expected 0", wb_err); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        drive(1'b1, 4'd14, 1'b0, 1'b1, 4'b0001, 1'b1);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
        step();
        n_checks++; if (pending !== 2'd0 || exec_valid !== 1'b0 || flags !== 4'b0001 || wb_err !== 1'b0) begin
            n_fail++; $display("FAIL flush_state: got pend=%0d ev=%b flags=%b err=%b expected 0 0 0001 0", pending, exec_valid, flags, wb_err); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'b0100, 1'b1);
`ifdef FLAG_BYPASS_EN
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %b expected 1", issue_ready); end
        step();
        n_checks++; if (exec_valid !== 1'b1 || exec_pass !== 1'b1 || pending !== 2'd0) begin
            n_fail++; $display("FAIL bypass_issue: got ev=%b ep=%b pend=%0d expected 1 1 0", exec_valid, exec_pass, pending); end
        drive(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0); step();
        drive(1'b1, 4'd1, 1'b1, 1'b0, 4'b0000, 1'b1); step();
        n_checks++; if (exec_pass !== 1'b1 || pending !== 2'd1) begin
            n_fail++; $display("FAIL bypass_setter: got ep=%b pend=%0d expected 1 1", exec_pass, pending); end
`else
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready: got %b expected 0", issue_ready); end
        step();
        n_checks++; if (exec_valid !== 1'b0 || flags !== 4'b0100 || pending !== 2'd0) begin
            n_fail++; $display("FAIL nobypass_wb: got ev=%b flags=%b pend=%0d expected 0 0100 0", exec_valid, flags, pending); end
        drive(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0); step();
        n_checks++; if (exec_valid !== 1'b1 || exec_pass !== 1'b1) begin
            n_fail++; $display("FAIL nobypass_issue: got ev=%b ep=%b expected 1 1", exec_valid, exec_pass); end
`endif
    endtask

    task automatic test_random();
        bit exp_rdy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 3));
            exp_rdy = m_ready();
            n_checks++; if (issue_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, issue_ready, exp_rdy); end
            step();
            n_checks++; if (flags !== m_flags || pending !== PW'(m_pending) || exec_valid !== m_ev
                            || exec_pass !== m_ep || wb_err !== m_err) begin
                n_fail++; $display("FAIL rand_state[%0d]: got f=%b p=%0d ev=%b ep=%b err=%b expected f=%b p=%0d ev=%b ep=%b err=%b",
                    i, flags, pending, exec_valid, exec_pass, wb_err, m_flags, m_pending, m_ev, m_ep, m_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_cond = 4'd0; issue_sets_flags = 1'b0;
        flush = 1'b0; nzcv = 4'd0; nzcv_writeback = 1'b0;
        model_reset();
        test_reset();
        test_cond_basic();
        test_hazard();
        test_full();
        test_signed_conds();
        test_wb_err();
        test_flush();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
